// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver: double-buffered frame, blanking gap between rows.
// Optional `LED_MATRIX_SCAN_BRIGHTNESS_EN adds a 3-bit brightness input that shortens the lit part of DRIVE.
module led_matrix_scan #(
  parameter int DWELL = 12500,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] frame_in,
  input  logic        frame_load,
  output logic        frame_ready,
  output logic        frame_sync,
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
  input  logic [2:0]  brightness,
`endif
  output logic [15:0] led
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_DRIVE = 1'b1;

  logic          r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_row;
  logic [63:0]   r_active;
  logic [63:0]   r_shadow;
  logic          r_pending;
  logic          r_sync;
  logic [15:0]   r_led;

  logic       w_blank_last;
  logic       w_drive_last;
  logic       w_wrap;
  logic [7:0] w_row_gnd;
  logic [7:0] w_cols;
  logic [7:0] w_cols_shown;

  assign w_blank_last = (r_cnt == CW'(BLANK - 1));
  assign w_drive_last = (r_cnt == CW'(DWELL - 1));
  assign w_wrap       = (r_state == ST_DRIVE) && w_drive_last && (r_row == 3'd7);
  assign w_row_gnd    = ~(8'd1 << r_row);
  assign w_cols       = r_active[{r_row, 3'b000} +: 8];

`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
  logic [31:0] w_lit_lim;
  assign w_lit_lim    = ((32'(brightness) + 32'd1) * 32'(DWELL)) >> 3;
  assign w_cols_shown = (32'(r_cnt) < w_lit_lim) ? w_cols : '0;
`else
  assign w_cols_shown = w_cols;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_BLANK;
      r_cnt     <= '0;
      r_row     <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_sync    <= 1'b0;
      r_led     <= 16'hFF00;
    end else begin
      r_sync <= 1'b0;
      // led is the pattern of the state held before this edge, so it lags the FSM by one cycle
      r_led  <= (r_state == ST_DRIVE) ? {w_row_gnd, w_cols_shown} : 16'hFF00;

      case (r_state)
        ST_BLANK: begin
          if (w_blank_last) begin
            r_state <= ST_DRIVE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          if (w_drive_last) begin
            r_row   <= r_row + 3'd1;
            r_state <= ST_BLANK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase

      // A load landing on the wrap cycle sees r_pending=0, so it is captured but swapped a frame later
      if (w_wrap && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
        r_sync    <= 1'b1;
      end else if (frame_load && !r_pending) begin
        r_shadow  <= frame_in;
        r_pending <= 1'b1;
      end
    end
  end

  assign frame_ready = ~r_pending;
  assign frame_sync  = r_sync;
  assign led         = r_led;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: time-based reference model, vector table and corner sequences.
module tb_led_matrix_scan;

`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
  localparam int D = 8;
`else
  localparam int D = 4;
`endif
  localparam int B  = 2;
  localparam int RP = B + D;
  localparam int P  = 8 * RP;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] frame_in;
  logic        frame_load;
  logic        frame_ready;
  logic        frame_sync;
  logic [15:0] led;
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
  logic [2:0]  brightness;
`endif

  led_matrix_scan #(.DWELL(D), .BLANK(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_in   (frame_in),
    .frame_load (frame_load),
    .frame_ready(frame_ready),
    .frame_sync (frame_sync),
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .led        (led)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: scan position derived purely from elapsed edges since reset
  int unsigned m_e;
  logic [63:0] m_act, m_sh;
  bit          m_pend;
  logic [15:0] m_led;
  bit          m_sync;
  logic [2:0]  m_bri = 3'd7;

  function automatic logic [15:0] pat(int unsigned pos, logic [63:0] act, logic [2:0] bri);
    int unsigned row, w, k;
    logic [7:0] cols, gnd;
    row = pos / RP;
    w   = pos % RP;
    if (w < B) return 16'hFF00;
    k    = w - B;
    cols = act[row*8 +: 8];
    gnd  = ~(8'd1 << row);
    if (k >= ((int'(bri) + 1) * D) / 8) cols = 8'h00;
    return {gnd, cols};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_n, input bit ld, input logic [63:0] fin);
    int unsigned pos;
    reset = rst_n; frame_load = ld; frame_in = fin;
    @(posedge clk);
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
    m_bri = brightness;
`endif
    if (!rst_n) begin
      m_e = 0; m_act = '0; m_sh = '0; m_pend = 0; m_led = 16'hFF00; m_sync = 0;
    end else begin
      pos    = m_e % P;
      m_led  = pat(pos, m_act, m_bri);
      m_sync = (pos == P - 1) && m_pend;
      if (m_sync) begin
        m_act = m_sh; m_pend = 0;
      end else if (ld && !m_pend) begin
        m_sh = fin; m_pend = 1;
      end
      m_e++;
    end
    #1;
    chk("led", led, m_led);
    chk("ready", frame_ready, !m_pend);
    chk("sync", frame_sync, m_sync);
  endtask

  task automatic wait_sync();
    bit found = 0;
    for (int i = 0; i < 2 * P + 4 && !found; i++) begin
      step(1, 0, '0);
      found = frame_sync;
    end
    chk("sync_wait", found, 1);
  endtask

  task automatic wait_gnd(input logic [7:0] gnd);
    bit found = 0;
    for (int i = 0; i < P + 4 && !found; i++) begin
      step(1, 0, '0);
      found = (led[15:8] == gnd);
    end
    chk("gnd_wait", found, 1);
  endtask

  typedef struct {
    logic [63:0] frame;
    logic [2:0]  row;
    logic [15:0] exp;
  } vec_t;

  localparam logic [63:0] DIAG = 64'h8040201008040201;
  localparam logic [63:0] FRM2 = 64'h0123456789ABCDEF;

  initial begin
    vec_t        tbl[12];
    logic [63:0] shown;
    int          n, runlen, lit, gcnt;
    bit          found;

    tbl[0]  = '{DIAG, 3'd0, 16'hFE01};
    tbl[1]  = '{DIAG, 3'd1, 16'hFD02};
    tbl[2]  = '{DIAG, 3'd2, 16'hFB04};
    tbl[3]  = '{DIAG, 3'd3, 16'hF708};
    tbl[4]  = '{DIAG, 3'd4, 16'hEF10};
    tbl[5]  = '{DIAG, 3'd5, 16'hDF20};
    tbl[6]  = '{DIAG, 3'd6, 16'hBF40};
    tbl[7]  = '{DIAG, 3'd7, 16'h7F80};
    tbl[8]  = '{FRM2, 3'd0, 16'hFEEF};
    tbl[9]  = '{FRM2, 3'd3, 16'hF789};
    tbl[10] = '{FRM2, 3'd5, 16'hDF45};
    tbl[11] = '{FRM2, 3'd7, 16'h7F01};

`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
    brightness = 3'd7;
`endif
    m_e = 0; m_act = '0; m_sh = '0; m_pend = 0; m_sync = 0;

    // Reset with random inputs, then exactly B blank cycles before row 0 drives
    for (int i = 0; i < 3; i++) step(0, 1'($urandom % 2), {$urandom, $urandom});
    chk("rst_led", led, 16'hFF00);
    chk("rst_ready", frame_ready, 1);
    for (int i = 0; i < B; i++) begin
      step(1, 0, '0);
      chk("rel_blank", led, 16'hFF00);
    end
    step(1, 0, '0);
    chk("rel_row0", led[15:8], 8'hFE);

    // Vector table; each new frame is loaded with an ignored second load behind it
    shown = '0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].frame !== shown) begin
        step(1, 1, tbl[i].frame);
        chk("ready_low", frame_ready, 0);
        step(1, 1, 64'hDEADBEEFCAFEF00D);
        wait_sync();
        chk("ready_at_sync", frame_ready, 1);
        shown = tbl[i].frame;
      end
      wait_gnd(~(8'd1 << tbl[i].row));
      chk("tbl_led", led, tbl[i].exp);
    end

    // Drive run length and frame period for row 0 of FRM2
    wait_gnd(8'hFE);
    runlen = 0; found = 0;
    for (int i = 0; i < P + 4 && !found; i++) begin
      runlen++;
      step(1, 0, '0);
      found = (led[15:8] != 8'hFE);
    end
    chk("drive_len", runlen, D);
    n = runlen; found = 0;
    for (int i = 0; i < P + 4 && !found; i++) begin
      n++;
      step(1, 0, '0);
      found = (led[15:8] == 8'hFE);
    end
    chk("frame_period", n, P);

    // Load on the row-7 DRIVE-last cycle: captured, but swapped one full frame later
    found = 0;
    for (int i = 0; i < P + 4 && !found; i++) begin
      found = ((m_e % P) == P - 1) && !m_pend;
      if (!found) step(1, 0, '0);
    end
    chk("bnd_reach", found, 1);
    step(1, 1, DIAG);
    chk("bnd_no_sync", frame_sync, 0);
    chk("bnd_captured", frame_ready, 0);
    n = 0; found = 0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      n++;
      step(1, 0, '0);
      found = frame_sync;
    end
    chk("bnd_delay", n, P);

    // Reset during row 4 DRIVE with a frame pending
    step(1, 1, FRM2);
    wait_gnd(8'hEF);
    step(0, 0, '0);
    step(0, 1, FRM2);
    chk("mid_rst_led", led, 16'hFF00);
    chk("mid_rst_ready", frame_ready, 1);
    wait_gnd(8'hFE);
    chk("mid_rst_cols", led[7:0], 8'h00);
    n = 0;
    for (int i = 0; i < P; i++) begin
      step(1, 0, '0);
      n += int'(frame_sync);
    end
    chk("mid_rst_nosync", n, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
      if ($urandom % 50 == 0) brightness = 3'($urandom);
`endif
      step(($urandom % 700) != 0, ($urandom % 6) == 0, {$urandom, $urandom});
    end

`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
    // Brightness: lit cycles out of D with the row ground held for all D
    step(0, 0, '0);
    step(1, 1, '1);
    wait_sync();
    for (int b = 1; b <= 7; b += 6) begin
      brightness = 3'(b);
      wait_gnd(8'hFF);
      found = 0;
      for (int i = 0; i < P && !found; i++) begin
        step(1, 0, '0);
        found = (led[15:8] != 8'hFF);
      end
      gcnt = 0; lit = 0;
      for (int i = 0; i < P && led[15:8] != 8'hFF; i++) begin
        gcnt++;
        lit += int'(led[7:0] == 8'hFF);
        step(1, 0, '0);
      end
      chk("bri_gnd", gcnt, D);
      chk("bri_lit", lit, ((b + 1) * D) / 8);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
